mdu: RTL

Multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu over several cycles and owns the HI/LO registers, which mthi/mtlo write and mfhi/mflo read. Its `busy` output goes to the hazard/forwarding unit. That unit stalls any multiply/divide-class instruction held in D while `start || busy` is high.

---
 rtl/mdu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched at start; the result commits on the edge where busy falls.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_next, lo_next;
    logic        accept;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        div_a, div_b, quot_mag, rem_mag, quot, rem;

    assign busy = (state == RUN);

    assign accept = (state == IDLE) && start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide runs on magnitudes through the shared unsigned divider,
    // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign div_signed = (op_q == OP_DIV);
    assign div_a      = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign div_b      = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign quot_mag   = (div_b != 32'd0) ? (div_a / div_b) : 32'd0;
    assign rem_mag    = (div_b != 32'd0) ? (div_a % div_b) : 32'd0;
    assign quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_mag) : quot_mag;
    assign rem        = (div_signed && a_q[31]) ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        state_next = state;
        count_next = count;
        hi_next    = HI;
        lo_next    = LO;
        case (state)
            IDLE: begin
                if (accept) begin
                    count_next = (MDUOp <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                    state_next = RUN;
                end else if (MDUOp == OP_MTHI) begin
                    hi_next = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = IDLE;
                    case (op_q)
                        OP_MULT: begin
                            hi_next = prod_s[63:32];
                            lo_next = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_next = prod_u[63:32];
                            lo_next = prod_u[31:0];
                        end
                        default: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != 32'd0) begin
                                hi_next = rem;
                                lo_next = quot;
                            end
                        end
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            HI    <= hi_next;
            LO    <= lo_next;
            if (accept) begin
                op_q <= MDUOp;
                a_q  <= A;
                b_q  <= B;
            end
        end
    end

endmodule
